// File: rtl/div_iter_pkg.sv
// Shared types and helpers for the iterative integer divider.
// Purely declarative: no logic, no latency, no backpressure.
// Op encoding matches the dispatch div_op field.
package div_iter_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_FIXUP   = 3'd2,
        ST_SPECIAL = 3'd3,
        ST_DONE    = 3'd4
    } div_state_t;

    function automatic logic op_is_signed(div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Dispatch request / writeback bundle between IDU1, the divider and the EXU writeback.
// Wires only: no latency; the request side is a valid/ready handshake.
// slave = divider side, master = dispatch/writeback side.
interface div_iter_if #(
    parameter int XLEN = 32
);
    logic            div_valid;
    logic            div_ready;
    logic [1:0]      div_op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] instr_tag_in;
    logic [31:0]     instr_in;
    logic            flush;
    logic            div_busy;
    logic [XLEN-1:0] div_wb_data;
    logic [4:0]      div_wb_rd_addr;
    logic            div_wb_rd_wr_en;
    logic [XLEN-1:0] instr_tag_out;
    logic [31:0]     instr_out;

    modport slave (
        input  div_valid, div_op, rs1_data, rs2_data, rd_addr,
               instr_tag_in, instr_in, flush,
        output div_ready, div_busy, div_wb_data, div_wb_rd_addr,
               div_wb_rd_wr_en, instr_tag_out, instr_out
    );

    modport master (
        output div_valid, div_op, rs1_data, rs2_data, rd_addr,
               instr_tag_in, instr_in, flush,
        input  div_ready, div_busy, div_wb_data, div_wb_rd_addr,
               div_wb_rd_wr_en, instr_tag_out, instr_out
    );
endinterface

// File: rtl/dff_rst.sv
// Generic register with asynchronous active-low reset to RST_VAL.
// Latency: one clock edge.
// No backpressure: loads d on every edge.
module dff_rst #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end
endmodule

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; no backpressure.
// The extra top bit of the shifted remainder makes the borrow the sign of the difference.
module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            bit_in,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);
    logic [XLEN+1:0] rem_sh;
    logic [XLEN+1:0] diff;

    assign rem_sh  = {rem_in, bit_in};
    assign diff    = rem_sh - {2'b00, divisor};
    assign q_bit   = ~diff[XLEN+1];
    assign rem_out = q_bit ? diff[XLEN:0] : rem_sh[XLEN:0];
endmodule

// File: rtl/div_iter.sv
// Iterative RV32M/RV64M DIV/DIVU/REM/REMU unit, BITS_PER_CYCLE quotient bits per cycle.
// Latency: NUM_ITER+2 cycles after accept (2 for divide-by-zero / signed overflow).
// Backpressure: div_ready only in IDLE; flush kills the op and gates a same-cycle strobe.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    div_iter_if.slave div
);
    localparam int NUM_ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW       = $clog2(NUM_ITER);
    localparam logic [CW-1:0]   LAST_ITER = CW'(NUM_ITER - 1);
    localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    // dvd holds the dividend on entry and accumulates quotient bits from the bottom.
    typedef struct packed {
        div_op_t         op;
        logic [4:0]      rd;
        logic [XLEN-1:0] tag;
        logic [31:0]     instr;
        logic [XLEN-1:0] dvd;
        logic [XLEN-1:0] dvs;
        logic [XLEN:0]   rem;
        logic            q_neg;
        logic            r_neg;
        logic [CW-1:0]   cnt;
    } dp_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic [XLEN-1:0] tag;
        logic [31:0]     instr;
    } wb_t;

    div_state_t state_q, state_d;
    logic [2:0] state_raw;
    dp_t        dp_q, dp_d;
    wb_t        wb_q, wb_d;

    dff_rst #(.W(3))           u_state (.clk(clk), .rst_n(rst_n), .d(state_d), .q(state_raw));
    dff_rst #(.W($bits(dp_t))) u_dp    (.clk(clk), .rst_n(rst_n), .d(dp_d),    .q(dp_q));
    dff_rst #(.W($bits(wb_t))) u_wb    (.clk(clk), .rst_n(rst_n), .d(wb_d),    .q(wb_q));

    assign state_q = div_state_t'(state_raw);

    logic [BITS_PER_CYCLE-1:0] q_bits;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        logic [XLEN:0] rem_i;
        logic [XLEN:0] rem_o;
        if (g == 0) begin : g_first
            assign rem_i = dp_q.rem;
        end else begin : g_next
            assign rem_i = g_step[g-1].rem_o;
        end
        div_iter_step #(.XLEN(XLEN)) u_step (
            .rem_in  (rem_i),
            .divisor (dp_q.dvs),
            .bit_in  (dp_q.dvd[XLEN-1-g]),
            .rem_out (rem_o),
            .q_bit   (q_bits[BITS_PER_CYCLE-1-g])
        );
    end

    logic            req_signed;
    logic            req_special;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_res;
    logic [XLEN-1:0] spc_res;
    div_op_t         req_op;

    always_comb begin
        req_op      = div_op_t'(div.div_op);
        req_signed  = op_is_signed(req_op);
        req_special = (div.rs2_data == '0) ||
                      (req_signed && div.rs1_data == MIN_INT && div.rs2_data == '1);

        quot_fix = dp_q.q_neg ? -dp_q.dvd : dp_q.dvd;
        rem_fix  = dp_q.r_neg ? -dp_q.rem[XLEN-1:0] : dp_q.rem[XLEN-1:0];
        fix_res  = op_is_rem(dp_q.op) ? rem_fix : quot_fix;

        // Special ops keep the raw operands: dvs==0 means divide-by-zero, else overflow.
        if (op_is_rem(dp_q.op)) spc_res = (dp_q.dvs == '0) ? dp_q.dvd : '0;
        else                    spc_res = (dp_q.dvs == '0) ? '1 : dp_q.dvd;
    end

    always_comb begin
        state_d = state_q;
        dp_d    = dp_q;
        wb_d    = wb_q;

        case (state_q)
            ST_IDLE: begin
                if (div.div_valid && !div.flush) begin
                    dp_d.op    = req_op;
                    dp_d.rd    = div.rd_addr;
                    dp_d.tag   = div.instr_tag_in;
                    dp_d.instr = div.instr_in;
                    dp_d.rem   = '0;
                    dp_d.cnt   = '0;
                    dp_d.q_neg = req_signed & (div.rs1_data[XLEN-1] ^ div.rs2_data[XLEN-1]);
                    dp_d.r_neg = req_signed & div.rs1_data[XLEN-1];
                    if (req_special) begin
                        dp_d.dvd = div.rs1_data;
                        dp_d.dvs = div.rs2_data;
                        state_d  = ST_SPECIAL;
                    end else begin
                        dp_d.dvd = (req_signed && div.rs1_data[XLEN-1]) ? -div.rs1_data : div.rs1_data;
                        dp_d.dvs = (req_signed && div.rs2_data[XLEN-1]) ? -div.rs2_data : div.rs2_data;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                dp_d.rem = g_step[BITS_PER_CYCLE-1].rem_o;
                dp_d.dvd = {dp_q.dvd[XLEN-BITS_PER_CYCLE-1:0], q_bits};
                dp_d.cnt = dp_q.cnt + CW'(1);
                if (dp_q.cnt == LAST_ITER) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                wb_d    = '{data: fix_res, rd: dp_q.rd, tag: dp_q.tag, instr: dp_q.instr};
                state_d = ST_DONE;
            end
            ST_SPECIAL: begin
                wb_d    = '{data: spc_res, rd: dp_q.rd, tag: dp_q.tag, instr: dp_q.instr};
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (div.flush) begin
            state_d = ST_IDLE;
            wb_d    = wb_q;
        end
    end

    assign div.div_ready       = (state_q == ST_IDLE);
    assign div.div_busy        = (state_q != ST_IDLE);
    assign div.div_wb_data     = wb_q.data;
    assign div.div_wb_rd_addr  = wb_q.rd;
    assign div.instr_tag_out   = wb_q.tag;
    assign div.instr_out       = wb_q.instr;
    assign div.div_wb_rd_wr_en = (state_q == ST_DONE) && (wb_q.rd != 5'd0) && !div.flush;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: radix-1 and radix-4 instances share one stimulus driver.
module tb_div_iter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sel;
    logic        v_valid, v_flush;
    logic [1:0]  v_op;
    logic [31:0] v_a, v_b, v_tag, v_instr;
    logic [4:0]  v_rd;

    div_iter_if #(.XLEN(32)) if1 ();
    div_iter_if #(.XLEN(32)) if4 ();

    assign if1.div_valid    = v_valid & ~sel;
    assign if4.div_valid    = v_valid & sel;
    assign if1.div_op       = v_op;
    assign if4.div_op       = v_op;
    assign if1.rs1_data     = v_a;
    assign if4.rs1_data     = v_a;
    assign if1.rs2_data     = v_b;
    assign if4.rs2_data     = v_b;
    assign if1.rd_addr      = v_rd;
    assign if4.rd_addr      = v_rd;
    assign if1.instr_tag_in = v_tag;
    assign if4.instr_tag_in = v_tag;
    assign if1.instr_in     = v_instr;
    assign if4.instr_in     = v_instr;
    assign if1.flush        = v_flush;
    assign if4.flush        = v_flush;

    div_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) u_div1 (.clk(clk), .rst_n(rst_n), .div(if1));
    div_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) u_div4 (.clk(clk), .rst_n(rst_n), .div(if4));

    logic        o_ready, o_busy, o_wr_en;
    logic [31:0] o_data, o_tag, o_instr;
    logic [4:0]  o_rd;
    assign o_ready = sel ? if4.div_ready       : if1.div_ready;
    assign o_busy  = sel ? if4.div_busy        : if1.div_busy;
    assign o_wr_en = sel ? if4.div_wb_rd_wr_en : if1.div_wb_rd_wr_en;
    assign o_data  = sel ? if4.div_wb_data     : if1.div_wb_data;
    assign o_tag   = sel ? if4.instr_tag_out   : if1.instr_tag_out;
    assign o_instr = sel ? if4.instr_out       : if1.instr_out;
    assign o_rd    = sel ? if4.div_wb_rd_addr  : if1.div_wb_rd_addr;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] r_data, r_tag, r_instr;
    logic [4:0]  r_rd;
    int          r_cyc, r_nstb;
    logic [63:0] r_rdy;

    // Accept edge closes cycle 0; each following negedge (+1) samples cycle 1, 2, ...
    task automatic run_op(input logic s, input logic [1:0] op, input logic [31:0] a, b,
                          input logic [4:0] rd, input logic [31:0] tag, input int flush_cyc);
        @(negedge clk);
        sel = s; v_op = op; v_a = a; v_b = b; v_rd = rd; v_tag = tag; v_instr = ~tag;
        #1;
        check("ready_before_req", {63'd0, o_ready}, 64'd1);
        v_valid = 1'b1;
        @(posedge clk);
        #1 v_valid = 1'b0;
        r_cyc = -1; r_nstb = 0; r_rdy = '0; r_data = '0; r_rd = '0;
        for (int cyc = 1; cyc < 50; cyc++) begin
            @(negedge clk);
            v_flush = (cyc == flush_cyc);
            #1;
            r_rdy[cyc] = o_ready;
            if (o_wr_en) begin
                r_nstb++;
                r_cyc  = cyc;
                r_data = o_data;
                r_rd   = o_rd;
            end
        end
        v_flush = 1'b0;
        r_tag   = o_tag;
        r_instr = o_instr;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; v_valid = 1'b0; v_flush = 1'b0;
        v_op = '0; v_a = '0; v_b = '0; v_tag = '0; v_instr = '0; v_rd = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready",  {63'd0, if1.div_ready}, 64'd1);
        check("rst_busy",   {63'd0, if1.div_busy}, 64'd0);
        check("rst_wr_en",  {63'd0, if4.div_wb_rd_wr_en}, 64'd0);
        check("rst_data",   {32'd0, if1.div_wb_data}, 64'd0);
        check("rst_tag",    {32'd0, if4.instr_tag_out}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(1'b0, DIVU, 32'd100, 32'd7, 5'd3, 32'h0000_1000, -1);
        check("divu_100_7_data", {32'd0, r_data}, 64'd14);
        check("divu_100_7_cyc",  64'(r_cyc), 64'd34);
        check("divu_100_7_nstb", 64'(r_nstb), 64'd1);
        check("divu_100_7_rd",   {59'd0, r_rd}, 64'd3);
        check("divu_100_7_tag",  {32'd0, r_tag}, 64'h1000);
        check("divu_100_7_instr", {32'd0, r_instr}, 64'hFFFF_EFFF);
        check("ready_low_c33",   {63'd0, r_rdy[33]}, 64'd0);
        check("ready_low_c34",   {63'd0, r_rdy[34]}, 64'd0);
        check("ready_high_c35",  {63'd0, r_rdy[35]}, 64'd1);

        run_op(1'b0, REMU, 32'd100, 32'd7, 5'd3, 32'h0000_1004, -1);
        check("remu_100_7", {32'd0, r_data}, 64'd2);

        run_op(1'b0, DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'h0000_1008, -1);
        check("div_m7_2", {32'd0, r_data}, 64'hFFFF_FFFD);
        run_op(1'b0, REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'h0000_100C, -1);
        check("rem_m7_2", {32'd0, r_data}, 64'hFFFF_FFFF);
        run_op(1'b0, REM, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'h0000_1010, -1);
        check("rem_7_m2", {32'd0, r_data}, 64'd1);
        run_op(1'b0, DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h0000_1014, -1);
        check("divu_min_m1", {32'd0, r_data}, 64'd0);
        check("divu_min_m1_cyc", 64'(r_cyc), 64'd34);

        run_op(1'b0, DIV, 32'd5, 32'd0, 5'd6, 32'h0000_1018, -1);
        check("div_5_0",       {32'd0, r_data}, 64'hFFFF_FFFF);
        check("div_5_0_cyc",   64'(r_cyc), 64'd2);
        check("div0_rdy_c1",   {63'd0, r_rdy[1]}, 64'd0);
        check("div0_rdy_c2",   {63'd0, r_rdy[2]}, 64'd0);
        check("div0_rdy_c3",   {63'd0, r_rdy[3]}, 64'd1);
        run_op(1'b0, REMU, 32'd5, 32'd0, 5'd6, 32'h0000_101C, -1);
        check("remu_5_0", {32'd0, r_data}, 64'd5);

        run_op(1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_1020, -1);
        check("div_ovf",     {32'd0, r_data}, 64'h8000_0000);
        check("div_ovf_cyc", 64'(r_cyc), 64'd2);
        run_op(1'b0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_1024, -1);
        check("rem_ovf", {32'd0, r_data}, 64'd0);

        run_op(1'b0, DIVU, 32'd100, 32'd7, 5'd5, 32'h0000_1028, 10);
        check("flush_calc_nstb",  64'(r_nstb), 64'd0);
        check("flush_calc_rdy10", {63'd0, r_rdy[10]}, 64'd0);
        check("flush_calc_rdy11", {63'd0, r_rdy[11]}, 64'd1);
        run_op(1'b0, DIVU, 32'd9, 32'd3, 5'd5, 32'h0000_102C, -1);
        check("divu_9_3_after_flush", {32'd0, r_data}, 64'd3);

        run_op(1'b0, DIV, 32'd5, 32'd0, 5'd7, 32'h0000_1030, 2);
        check("flush_done_nstb", 64'(r_nstb), 64'd0);

        run_op(1'b1, DIVU, 32'hFFFF_FFFF, 32'h10, 5'd9, 32'h0000_2000, -1);
        check("r4_divu_data", {32'd0, r_data}, 64'h0FFF_FFFF);
        check("r4_divu_cyc",  64'(r_cyc), 64'd10);
        run_op(1'b1, DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h0000_2004, -1);
        check("r4_div_m7_2", {32'd0, r_data}, 64'hFFFF_FFFD);
        run_op(1'b1, DIVU, 32'd20, 32'd4, 5'd0, 32'h1234_5678, -1);
        check("rd0_nstb", 64'(r_nstb), 64'd0);
        check("rd0_tag",  {32'd0, r_tag}, 64'h1234_5678);
        check("rd0_data", {32'd0, o_data}, 64'd5);

        // Async reset in the middle of a radix-1 divide.
        @(negedge clk);
        sel = 1'b0; v_op = DIVU; v_a = 32'd100; v_b = 32'd7; v_rd = 5'd3; v_valid = 1'b1;
        @(posedge clk);
        #1 v_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  {63'd0, o_busy}, 64'd0);
        check("arst_ready", {63'd0, o_ready}, 64'd1);
        check("arst_data",  {32'd0, o_data}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        r_nstb = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #1;
            if (o_wr_en) r_nstb++;
        end
        check("arst_no_wb", 64'(r_nstb), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
